// File: rtl/prog_counter.sv
// prog_counter: runtime-programmable up/down counter with limits, wrap/saturate/one-shot modes, tc/done/ovf flags.
// Ports: clk, rst (sync, active-low), en, load, load_value, step, dir, mode, lim_lo, lim_hi, clr_ovf -> count, tc, done, ovf, cfg_err.
// Optional: COUNTER_PRESCALE_EN adds PRESCALE_WIDTH and input prescale (advance once every prescale+1 enabled cycles).
module prog_counter #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
`ifdef COUNTER_PRESCALE_EN
  , parameter int PRESCALE_WIDTH = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] lim_lo,
  input  logic [DATA_WIDTH-1:0] lim_hi,
  input  logic                  clr_ovf,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0] prescale,
`endif
  output logic [DATA_WIDTH-1:0] count,
  output logic                  tc,
  output logic                  done,
  output logic                  ovf,
  output logic                  cfg_err
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH:0] step_x, sum, diff;
  logic [DATA_WIDTH-1:0] count_nx, lim, wrap_tgt, nat;
  logic tc_nx, ovf_set, adv, hit, over, wrap, sat, oneshot, psc_hit;
  assign cfg_err  = lim_lo > lim_hi;
  assign done     = state == HALT;
  assign wrap     = mode == 2'b00 || mode == 2'b11;
  assign sat      = mode == 2'b01;
  assign oneshot  = mode == 2'b10;
  assign step_x   = {{(DATA_WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
  assign sum      = {1'b0, count} + step_x;
  // diff[DATA_WIDTH] is the borrow out of the subtraction
  assign diff     = {1'b0, count} - step_x;
  assign lim      = dir ? lim_lo : lim_hi;
  assign wrap_tgt = dir ? lim_hi : lim_lo;
  assign nat      = dir ? diff[DATA_WIDTH-1:0] : sum[DATA_WIDTH-1:0];
  assign hit      = dir ? (!diff[DATA_WIDTH] && diff[DATA_WIDTH-1:0] == lim_lo) : (sum == {1'b0, lim_hi});
  assign over     = dir ? (diff[DATA_WIDTH] || diff[DATA_WIDTH-1:0] < lim_lo) : (sum > {1'b0, lim_hi});
  assign adv      = en && !load && step != '0 && !cfg_err && state == RUN && psc_hit;
`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] psc;
  assign psc_hit = psc == prescale;
  always_ff @(posedge clk)
    if (!rst || load) psc <= '0;
    else if (en && state == RUN) psc <= psc_hit ? '0 : psc + 1'b1;
`else
  assign psc_hit = 1'b1;
`endif
  always_ff @(posedge clk)
    if (!rst) state <= RUN;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (load) state_nx = RUN;
    else if (adv && oneshot && (hit || over)) state_nx = HALT;
  end
  always_comb begin
    count_nx = load ? load_value : count;
    tc_nx    = 1'b0;
    ovf_set  = 1'b0;
    if (adv) begin
      count_nx = hit ? lim : over ? (wrap ? wrap_tgt : lim) : nat;
      // saturating at a limit already held is not a new terminal event
      tc_nx    = hit || (over && (!sat || count != lim));
      ovf_set  = over && wrap;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      count <= RESET_VALUE;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nx;
      tc    <= tc_nx;
      ovf   <= ovf_set || (ovf && !clr_ovf);
    end
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed self-checking bench for prog_counter.
module tb_prog_counter;
  logic clk = 1'b0, rst, en, load, dir, clr_ovf;
  logic [15:0] load_value, lim_lo, lim_hi, count;
  logic [7:0] step;
  logic [1:0] mode;
  logic tc, done, ovf, cfg_err;
  int checks = 0, errors = 0;
`ifdef COUNTER_PRESCALE_EN
  logic [7:0] prescale = 8'd0;
`endif

  prog_counter dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_value(load_value),
    .step(step), .dir(dir), .mode(mode), .lim_lo(lim_lo), .lim_hi(lim_hi),
    .clr_ovf(clr_ovf),
`ifdef COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(count), .tc(tc), .done(done), .ovf(ovf), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    en = 1'b0; load = 1'b1; load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; load = 1'b0; dir = 1'b0; clr_ovf = 1'b0;
    load_value = 16'd0; lim_lo = 16'd0; lim_hi = 16'hffff; step = 8'd1; mode = 2'b00;
    tick(); tick();
    rst = 1'b1;
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({tc, done, ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got tc/done/ovf=%b want 000", {tc, done, ovf}); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
  endtask

  task automatic test_wrap_up;
    logic [15:0] ec [4] = '{16'd2, 16'd5, 16'd8, 16'd2};
    logic et [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    lim_lo = 16'd2; lim_hi = 16'd10; step = 8'd3; dir = 1'b0; mode = 2'b00;
    do_load(16'd8);
    checks++; if (count !== 16'd8 || tc !== 1'b0) begin errors++; $display("FAIL wrap_load got count=%0d tc=%b want 8 0", count, tc); end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clr_ovf = (i == 0);
      tick();
      checks++;
      if (count !== ec[i] || tc !== et[i] || ovf !== 1'b1) begin
        errors++; $display("FAIL wrap_up[%0d] got count=%0d tc=%b ovf=%b want %0d %b 1", i, count, tc, ovf, ec[i], et[i]);
      end
    end
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0 || count !== 16'd2) begin errors++; $display("FAIL wrap_clr_ovf got ovf=%b count=%0d want 0 2", ovf, count); end
  endtask

  task automatic test_sat_down;
    logic [15:0] ec [4] = '{16'd8, 16'd5, 16'd5, 16'd5};
    logic et [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    lim_lo = 16'd5; lim_hi = 16'd100; step = 8'd4; dir = 1'b1; mode = 2'b01;
    do_load(16'd12);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== ec[i] || tc !== et[i] || ovf !== 1'b0) begin
        errors++; $display("FAIL sat_down[%0d] got count=%0d tc=%b ovf=%b want %0d %b 0", i, count, tc, ovf, ec[i], et[i]);
      end
    end
  endtask

  task automatic test_oneshot;
    logic [15:0] ec [5] = '{16'd2, 16'd4, 16'd6, 16'd6, 16'd6};
    logic et [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic ed [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    lim_lo = 16'd0; lim_hi = 16'd6; step = 8'd2; dir = 1'b0; mode = 2'b10;
    do_load(16'd0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count !== ec[i] || tc !== et[i] || done !== ed[i]) begin
        errors++; $display("FAIL oneshot[%0d] got count=%0d tc=%b done=%b want %0d %b %b", i, count, tc, done, ec[i], et[i], ed[i]);
      end
    end
    load = 1'b1; load_value = 16'd1;
    tick();
    load = 1'b0;
    checks++; if (count !== 16'd1 || done !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL oneshot_reload got count=%0d done=%b tc=%b want 1 0 0", count, done, tc); end
    tick();
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL oneshot_resume got %0d want 3", count); end
    en = 1'b0;
  endtask

  task automatic test_edges;
    lim_lo = 16'd0; lim_hi = 16'd100; mode = 2'b00; dir = 1'b0; step = 8'd0;
    do_load(16'd50);
    en = 1'b1;
    tick(); tick();
    checks++; if (count !== 16'd50 || tc !== 1'b0) begin errors++; $display("FAIL step0 got count=%0d tc=%b want 50 0", count, tc); end
    step = 8'd1; lim_lo = 16'd20; lim_hi = 16'd10;
    #1;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err got %b want 1", cfg_err); end
    tick(); tick();
    checks++; if (count !== 16'd50 || tc !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL cfg_freeze got count=%0d tc=%b ovf=%b want 50 0 0", count, tc, ovf); end
    lim_lo = 16'd0; lim_hi = 16'd100; step = 8'd5; load = 1'b1; load_value = 16'd7;
    tick();
    load = 1'b0;
    checks++; if (count !== 16'd7) begin errors++; $display("FAIL load_over_en got %0d want 7", count); end
    tick();
    checks++; if (count !== 16'd12) begin errors++; $display("FAIL count_after_load got %0d want 12", count); end
    dir = 1'b1; lim_lo = 16'd3; lim_hi = 16'd20;
    do_load(16'd4);
    en = 1'b1;
    tick();
    checks++; if (count !== 16'd20 || tc !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL down_borrow_wrap got count=%0d tc=%b ovf=%b want 20 1 1", count, tc, ovf); end
    tick();
    checks++; if (count !== 16'd15 || tc !== 1'b0) begin errors++; $display("FAIL down_after_wrap got count=%0d tc=%b want 15 0", count, tc); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (count !== 16'd0 || ovf !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL mid_reset got count=%0d ovf=%b tc=%b want 0 0 0", count, ovf, tc); end
    en = 1'b0; dir = 1'b0;
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescale;
    logic [15:0] ec [6] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
    logic [15:0] el [4] = '{16'd10, 16'd10, 16'd10, 16'd11};
    lim_lo = 16'd0; lim_hi = 16'd1000; step = 8'd1; dir = 1'b0; mode = 2'b00; prescale = 8'd2;
    do_load(16'd0);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (count !== ec[i]) begin errors++; $display("FAIL prescale[%0d] got %0d want %0d", i, count, ec[i]); end
    end
    tick();
    load = 1'b1; load_value = 16'd10;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0;
      checks++; if (count !== el[i]) begin errors++; $display("FAIL prescale_reload[%0d] got %0d want %0d", i, count, el[i]); end
    end
    en = 1'b0; prescale = 8'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_oneshot();
    test_edges();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
